// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared widths and FSM encoding for spi_reg_arbiter
package spi_reg_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester after the last grant
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        int cand;
        cand  = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        // Scan starting one past the last winner so the previous grantee comes last.
        for (int off = 1; off <= N; off++) begin
            cand = int'(last) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_reg_arbiter.sv
// rtl/spi_reg_arbiter.sv - shares the single-port register bank between SPI and local requesters
module spi_reg_arbiter
    import spi_reg_pkg::*;
#(
    parameter int NR_LOC = 2,
    parameter int NR_RW  = 4,
    parameter int NR_RO  = 12
) (
    input  logic                         sysClk,
    input  logic                         usrReset,
    input  logic [NR_LOC:0]              req,
    input  logic [NR_LOC:0]              we,
    input  logic [ADDR_W*(NR_LOC+1)-1:0] addr,
    input  logic [DATA_W*(NR_LOC+1)-1:0] wdata,
    output logic [NR_LOC:0]              ack,
    output logic                         err,
    output logic [DATA_W-1:0]            rdata,
    output logic [ADDR_W-1:0]            regAddr,
    output logic                         regWe,
    output logic [DATA_W-1:0]            regWdata,
    input  logic [DATA_W-1:0]            regRdata
);

    localparam int NS = NR_LOC + 1;
    localparam int IW = $clog2(NS);
    localparam logic [ADDR_W:0] RW_LIM  = (ADDR_W+1)'(NR_RW);
    localparam logic [ADDR_W:0] TOP_LIM = (ADDR_W+1)'(NR_RW + NR_RO);

    state_t            state_q, state_d;
    logic [IW-1:0]     slot_q, slot_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              we_q, we_d;
    logic [NS-1:0]     ack_d;
    logic              err_d;
    logic [DATA_W-1:0] rdata_d;
    logic [ADDR_W-1:0] regAddr_d;
    logic              regWe_d;
    logic [DATA_W-1:0] regWdata_d;

    logic [NS-1:0]     gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              wr_ok;
    logic              in_range;
    logic              reject;

    rr_arbiter #(
        .N  (NS),
        .IW (IW)
    ) u_arb (
        .req   (req),
        .last  (ptr_q),
        .grant (gnt),
        .idx   (gnt_idx),
        .valid (gnt_valid)
    );

    assign sel_we    = |(we & gnt);
    assign sel_addr  = addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = wdata[int'(gnt_idx)*DATA_W +: DATA_W];

    // regAddr doubles as the latched address for the whole transaction.
    assign wr_ok    = {1'b0, regAddr} < RW_LIM;
    assign in_range = {1'b0, regAddr} < TOP_LIM;
    assign reject   = (we_q && !wr_ok) || !in_range;

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        ptr_d      = ptr_q;
        we_d       = we_q;
        ack_d      = '0;
        err_d      = 1'b0;
        rdata_d    = rdata;
        regAddr_d  = regAddr;
        regWe_d    = 1'b0;
        regWdata_d = regWdata;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    slot_d     = gnt_idx;
                    we_d       = sel_we;
                    regAddr_d  = sel_addr;
                    regWdata_d = sel_wdata;
                    regWe_d    = sel_we && ({1'b0, sel_addr} < RW_LIM);
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    ack_d[slot_q] = 1'b1;
                    err_d         = reject;
                    state_d       = ACK;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rdata_d       = in_range ? regRdata : '0;
                ack_d[slot_q] = 1'b1;
                err_d         = reject;
                state_d       = ACK;
            end
            ACK: begin
                ptr_d   = slot_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysClk or posedge usrReset) begin
        if (usrReset) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            ptr_q    <= IW'(NR_LOC);
            we_q     <= 1'b0;
            ack      <= '0;
            err      <= 1'b0;
            rdata    <= '0;
            regAddr  <= '0;
            regWe    <= 1'b0;
            regWdata <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            ptr_q    <= ptr_d;
            we_q     <= we_d;
            ack      <= ack_d;
            err      <= err_d;
            rdata    <= rdata_d;
            regAddr  <= regAddr_d;
            regWe    <= regWe_d;
            regWdata <= regWdata_d;
        end
    end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// tb/tb_spi_reg_arbiter.sv - scoreboard bench for spi_reg_arbiter
module tb_spi_reg_arbiter;

    localparam int NR_LOC = 2;
    localparam int NR_RW  = 4;
    localparam int NR_RO  = 10;
    localparam int NS     = NR_LOC + 1;

    logic            sysClk   = 1'b0;
    logic            usrReset = 1'b1;
    logic [NS-1:0]   req      = '0;
    logic [NS-1:0]   we       = '0;
    logic [4*NS-1:0] addr     = '0;
    logic [32*NS-1:0] wdata   = '0;
    logic [NS-1:0]   ack;
    logic            err;
    logic [31:0]     rdata;
    logic [3:0]      regAddr;
    logic            regWe;
    logic [31:0]     regWdata;
    logic [31:0]     regRdata = '0;

    typedef struct {
        int          slot;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } ack_exp_t;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        int          cyc;
    } we_exp_t;

    ack_exp_t    aq[$];
    we_exp_t     wq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic        bank_init = 1'b1;
    logic [31:0] mem [16];

    spi_reg_arbiter #(
        .NR_LOC (NR_LOC),
        .NR_RW  (NR_RW),
        .NR_RO  (NR_RO)
    ) dut (
        .sysClk   (sysClk),
        .usrReset (usrReset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .ack      (ack),
        .err      (err),
        .rdata    (rdata),
        .regAddr  (regAddr),
        .regWe    (regWe),
        .regWdata (regWdata),
        .regRdata (regRdata)
    );

    always #5 sysClk = ~sysClk;

    always @(posedge sysClk) cyc <= cyc + 1;

    // Bank model: synchronous write, read data one cycle after the address.
    always @(posedge sysClk) begin
        if (bank_init) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= (i == 4) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(i);
            end
        end else begin
            if (regWe) mem[regAddr] <= regWdata;
            regRdata <= mem[regAddr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge sysClk) begin
        ack_exp_t e;
        we_exp_t  w;
        if (!usrReset) begin
            if (regWe) begin
                if (wq.size() == 0) begin
                    check("regwe_unexpected", 32'(regWe), 32'd0);
                end else begin
                    w = wq.pop_front();
                    check("regwe_addr", 32'(regAddr), 32'(w.addr));
                    check("regwe_data", regWdata, w.data);
                    check("regwe_cycle", 32'(cyc), 32'(w.cyc));
                end
            end
            if (ack != '0) begin
                if (aq.size() == 0) begin
                    check("ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    e = aq.pop_front();
                    check("ack_slot", 32'(ack), 32'd1 << e.slot);
                    check("ack_err", 32'(err), 32'(e.err));
                    check("ack_rdata", rdata, e.rdata);
                    if (e.cyc >= 0) check("ack_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (err) begin
                check("err_without_ack", 32'(err), 32'd0);
            end
        end
    end

    task automatic push_exp(input int s, input logic e_err, input logic [31:0] e_rd, input int c);
        ack_exp_t e;
        e.slot  = s;
        e.err   = e_err;
        e.rdata = e_rd;
        e.cyc   = c;
        aq.push_back(e);
    endtask

    task automatic drive(input int s, input logic w, input logic [3:0] a, input logic [31:0] d);
        int t;
        we[s]            = w;
        addr[s*4 +: 4]   = a;
        wdata[s*32 +: 32] = d;
        req[s]           = 1'b1;
        t = 0;
        while (!ack[s] && t < 40) begin
            @(negedge sysClk);
            t++;
        end
        if (!ack[s]) check($sformatf("ack_timeout_slot%0d", s), 32'(ack[s]), 32'd1);
        req[s] = 1'b0;
    endtask

    task automatic do_access(input int s, input logic w, input logic [3:0] a, input logic [31:0] d,
                             input logic e_err, input logic [31:0] e_rd);
        we_exp_t x;
        push_exp(s, e_err, e_rd, cyc + (w ? 2 : 3));
        if (w && !e_err) begin
            x.addr = a;
            x.data = d;
            x.cyc  = cyc + 1;
            wq.push_back(x);
        end
        drive(s, w, a, d);
        @(negedge sysClk);
    endtask

    task automatic slot_loop(input int s);
        for (int r = 0; r < 3; r++) begin
            drive(s, 1'b0, 4'(5 + s), 32'd0);
            @(negedge sysClk);
        end
    endtask

    initial begin
        int t;
        repeat (3) @(negedge sysClk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_regaddr", 32'(regAddr), 32'd0);
        check("rst_regwe", 32'(regWe), 32'd0);
        check("rst_regwdata", regWdata, 32'd0);
        bank_init = 1'b0;
        usrReset  = 1'b0;
        @(negedge sysClk);

        do_access(0, 1'b1, 4'd1,  32'h0123_4567, 1'b0, 32'h0000_0000);
        do_access(1, 1'b0, 4'd1,  32'h0,         1'b0, 32'h0123_4567);
        do_access(0, 1'b1, 4'd4,  32'h1234_5678, 1'b1, 32'h0123_4567);
        do_access(2, 1'b0, 4'd4,  32'h0,         1'b0, 32'hDEAD_BEEF);
        do_access(0, 1'b0, 4'd15, 32'h0,         1'b1, 32'h0000_0000);
        do_access(1, 1'b0, 4'd13, 32'h0,         1'b0, 32'hA000_000D);
        do_access(2, 1'b1, 4'd3,  32'hCAFE_F00D, 1'b0, 32'hA000_000D);
        do_access(0, 1'b0, 4'd3,  32'h0,         1'b0, 32'hCAFE_F00D);
        do_access(1, 1'b1, 4'd14, 32'h0000_0055, 1'b1, 32'hCAFE_F00D);
        do_access(2, 1'b0, 4'd14, 32'h0,         1'b1, 32'h0000_0000);

        // All three slots contend; last grant was slot 2, so rotation starts at 0.
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < 3; s++) push_exp(s, 1'b0, 32'hA000_0005 + 32'(s), -1);
        end
        fork
            slot_loop(0);
            slot_loop(1);
            slot_loop(2);
        join
        @(negedge sysClk);

        we[1] = 1'b0;
        addr[4 +: 4] = 4'd2;
        req[1] = 1'b1;
        repeat (2) @(negedge sysClk);
        usrReset = 1'b1;
        req[1]   = 1'b0;
        @(negedge sysClk);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_regwe", 32'(regWe), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        @(negedge sysClk);
        usrReset = 1'b0;
        do_access(2, 1'b0, 4'd6, 32'h0, 1'b0, 32'hA000_0006);
        do_access(0, 1'b0, 4'd5, 32'h0, 1'b0, 32'hA000_0005);

        // Reset must restore the pointer so slot 0 beats slot 2.
        usrReset = 1'b1;
        repeat (2) @(negedge sysClk);
        usrReset = 1'b0;
        push_exp(0, 1'b0, 32'hA000_0008, cyc + 3);
        push_exp(2, 1'b0, 32'hA000_0009, -1);
        fork
            drive(0, 1'b0, 4'd8, 32'h0);
            drive(2, 1'b0, 4'd9, 32'h0);
        join
        @(negedge sysClk);

        t = 0;
        while ((aq.size() != 0 || wq.size() != 0) && t < 50) begin
            @(negedge sysClk);
            t++;
        end
        check("ack_queue_drained", 32'(aq.size()), 32'd0);
        check("regwe_queue_drained", 32'(wq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion before %0d cycles", cyc);
        $fatal(1);
    end

endmodule

// File: doc/spi_reg_arbiter.md
# spi_reg_arbiter

Shares the single-port 32-bit register bank behind the SPI message interface between the SPI side and N local FPGA requesters. Each access is a req/ack transaction. A round-robin arbiter picks one requester, the block sequences the register-bank port through a small state machine, and it enforces read-only protection on the upper register range. It sits between the SPI message interface, the local logic, and the register storage, all in the `sysClk` domain.

## Interface
Parameters:
- `NR_LOC`, 2: number of local requesters (1..7).
- `NR_RW`, 4: registers 0..NR_RW-1 are read/write.
- `NR_RO`, 12: registers NR_RW..NR_RW+NR_RO-1 are read-only from the requesters. NR_RW+NR_RO ≤ 16.

Ports (requester index 0 = SPI, 1..NR_LOC = local; packed vectors, slot k at `[k*W +: W]`):
- `sysClk` in, 1: system clock.
- `usrReset` in, 1: reset, asynchronous, active-high.
- `req` in, NR_LOC+1: access request per slot; held until that slot's `ack`.
- `we` in, NR_LOC+1: 1 = write, 0 = read; stable while `req` is high.
- `addr` in, 4*(NR_LOC+1): register index per slot.
- `wdata` in, 32*(NR_LOC+1): write data per slot.
- `ack` out, NR_LOC+1: one-cycle completion pulse to the granted slot.
- `err` out, 1: one-cycle pulse coincident with `ack` when the access was rejected.
- `rdata` out, 32: read result; valid with `ack`, held until the next read completes.
- `regAddr` out, 4: bank address.
- `regWe` out, 1: bank write strobe.
- `regWdata` out, 32: bank write data.
- `regRdata` in, 32: bank read data, valid 1 cycle after `regAddr`.

## Operation
- States: IDLE, ACCESS, CAPTURE, ACK.
- IDLE: if any `req` bit is set, the round-robin arbiter picks the first requesting slot after the last granted slot (pointer resets to "last = NR_LOC", so slot 0 wins first). The block latches slot, `we`, `addr` and `wdata`, then goes to ACCESS.
- ACCESS: drives `regAddr` and `regWdata`.
  - `regWe` = latched `we` AND addr < NR_RW.
  - Write → ACK. Read → CAPTURE.
- CAPTURE: registers `rdata` ← `regRdata`. If addr ≥ NR_RW+NR_RO, `rdata` ← 0 instead. → ACK.
- ACK: pulses `ack[slot]`. `err` = 1 if (write and addr ≥ NR_RW) or addr ≥ NR_RW+NR_RO. Updates the pointer to slot. → IDLE.
- A requester must drop `req` in the cycle after `ack`. A `req` still high in IDLE is a new request.
- `req` changes in slots other than the granted one are ignored until IDLE. Deasserting the granted `req` mid-transaction does not abort it; the transaction completes.
- `regWe` is high for exactly one cycle per accepted write and never for rejected writes.

## Timing
- Reset values: state IDLE, `ack` 0, `err` 0, `rdata` 0, `regAddr` 0, `regWe` 0, `regWdata` 0, pointer = NR_LOC.
- With `req` sampled high in IDLE at cycle n:
  - ACCESS in n+1 (`regWe` high in n+1 for writes).
  - Write: `ack` in n+2.
  - Read: CAPTURE in n+2, `ack` and `rdata` valid in n+3.
- Back-to-back: next grant decision in the IDLE cycle after ACK. Minimum period is 3 cycles for writes and 4 for reads.
- Simultaneous requests: granted in rotation. With all slots requesting continuously, each slot is served once per NR_LOC+1 transactions.
- Asynchronous reset mid-transaction: immediately returns to IDLE. Any pending `ack`, `regWe` or `err` is cleared and never emitted.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `spi_reg_pkg`: `DATA_W` = 32, `ADDR_W` = 4, and the state encoding type (IDLE/ACCESS/CAPTURE/ACK).
- Sub-module `rr_arbiter` (parameter N): request vector plus last-grant pointer in, one-hot grant and index out; combinational. The pointer register lives in the parent.

## Test plan
- Single SPI write: slot 0, addr 1, data 0x01234567 → `regWe` high exactly in n+1 with `regAddr` = 1; `ack[0]` in n+2; `err` 0.
- Read after write: slot 1 reads addr 1 → `ack[1]` in n+3 with `rdata` = 0x01234567; `regWe` never high.
- RO protection: slot 0 writes 0x12345678 to addr 4 → `regWe` stays 0, `ack[0]` and `err` pulse together. A subsequent read of addr 4 returns the bank value (e.g. 0xDEADBEEF) with `err` 0.
- Out of range: read addr 15 with NR_RW+NR_RO = 14 → `rdata` = 0, `err` = 1.
- Fairness: all three slots request continuously for 9 transactions → grant order 0,1,2,0,1,2,0,1,2, with no slot acked twice in a row.
- Reset mid-read: assert `usrReset` in CAPTURE → no `ack`, `rdata` = 0, state IDLE. After release, a pending slot-2 request is served first only if it is the sole requester; otherwise slot 0 wins.
